// File: rtl/cam_pkg.sv
//------------------------------------------------------------------------------
// Module      : cam_pkg
// Description : Shared types and constants for the camera frame writer:
//               capture FSM state encoding, memory command instruction code
//               and counter widths.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cam_pkg;

   // Capture FSM states, explicitly encoded
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_SYNC    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_FLUSH   = 3'd4,
      ST_DONE    = 3'd5
   } cap_state_t;

   // Memory-controller command instruction used for every burst (write)
   localparam logic [2:0] c_cmd_instr_wr = 3'b000;

   // Width of the per-frame byte counter (covers 160x120x4 with margin)
   localparam int c_byte_cnt_w = 24;

   // Width of the pending (written but not yet commanded) word counter
   localparam int c_pend_w = 16;

endpackage

`default_nettype wire

// File: rtl/cam_sync_edge.sv
//------------------------------------------------------------------------------
// Module      : cam_sync_edge
// Description : Brings the asynchronous camera pins into the clk domain with
//               two-flop synchronisers and flags rising edges of the pixel
//               clock. Data and pclk share the same depth so a byte is sampled
//               together with the pclk edge it belongs to.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cam_sync_edge
   import cam_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cam_pclk,
   input  logic       cam_href,
   input  logic       cam_vsync,
   input  logic [7:0] cam_data,
   output logic       pclk_rise,
   output logic       href_s,
   output logic       vsync_s,
   output logic [7:0] data_s
);

   // [0] metastable stage, [1] synchronised, [2] previous synchronised value
   logic [2:0] r_pclk_sh;
   logic [1:0] r_href_sh;
   logic [1:0] r_vsync_sh;
   logic [7:0] r_data_s1;
   logic [7:0] r_data_s2;

   // Two-flop synchronisers plus one history stage on pclk for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pclk_sh  <= '0;
         r_href_sh  <= '0;
         r_vsync_sh <= '0;
         r_data_s1  <= '0;
         r_data_s2  <= '0;
      end else begin
         r_pclk_sh  <= {r_pclk_sh[1:0], cam_pclk};
         r_href_sh  <= {r_href_sh[0], cam_href};
         r_vsync_sh <= {r_vsync_sh[0], cam_vsync};
         r_data_s1  <= cam_data;
         r_data_s2  <= r_data_s1;
      end
   end

   assign pclk_rise = r_pclk_sh[1] & ~r_pclk_sh[2];
   assign href_s    = r_href_sh[1];
   assign vsync_s   = r_vsync_sh[1];
   assign data_s    = r_data_s2;

endmodule

`default_nettype wire

// File: rtl/cam_frame_writer.sv
//------------------------------------------------------------------------------
// Module      : cam_frame_writer
// Description : Captures one camera frame per begin_cap, packs bytes
//               little-endian into DATA_W words for a write FIFO and issues
//               burst write commands. Partial words and short final bursts
//               are flushed at end of frame.
//               Optional macro CAM_DECIMATE_EN: keep only even pixels of even
//               lines (quarter-size frame).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cam_frame_writer
   import cam_pkg::*;
#(
   parameter int          H_RES         = 160,
   parameter int          V_RES         = 120,
   parameter int          BYTES_PER_PIX = 2,
   parameter int          DATA_W        = 32,
   parameter int          BURST_LEN     = 16,
   parameter logic [29:0] BASE_ADDR     = 30'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              begin_cap,
   input  logic              abort,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow,
   input  logic              cam_pclk,
   input  logic              cam_href,
   input  logic              cam_vsync,
   input  logic [7:0]        cam_data,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_full,
   output logic              cmd_en,
   output logic [5:0]        cmd_bl,
   output logic [29:0]       cmd_addr,
   input  logic              cmd_full
);

   localparam int c_bpw    = DATA_W / 8;
   localparam int c_pack_w = (c_bpw > 1) ? $clog2(c_bpw) : 1;
   localparam logic [c_pack_w-1:0] c_pack_last = c_pack_w'(c_bpw - 1);
`ifdef CAM_DECIMATE_EN
   localparam int c_total = H_RES * V_RES * BYTES_PER_PIX / 4;
`else
   localparam int c_total = H_RES * V_RES * BYTES_PER_PIX;
`endif
   localparam logic [c_byte_cnt_w-1:0] c_total_cnt = c_byte_cnt_w'(c_total);
   localparam logic [c_pend_w-1:0]     c_burst     = c_pend_w'(BURST_LEN);
   localparam logic [5:0]              c_bl_full   = 6'(BURST_LEN - 1);
   localparam logic [29:0]             c_addr_step = 30'(BURST_LEN * DATA_W / 8);

   cap_state_t r_state;
   cap_state_t w_state_nxt;

   logic                    w_pclk_rise;
   logic                    w_href_s;
   logic                    w_vsync_s;
   logic [7:0]              w_byte;
   logic                    r_vsync_d;
   logic                    w_vsync_rise;
   logic                    w_take;
   logic                    w_store;
   logic                    w_capture;
   logic                    w_start;
   logic                    w_abort;
   logic                    w_cnt_hit;

   logic [c_pack_w-1:0]     r_pack_cnt;
   logic [DATA_W-1:0]       r_pack_data;
   logic [DATA_W-1:0]       w_word;
   logic                    w_word_done;
   logic                    w_flush_push;
   logic                    w_push_req;
   logic                    w_push;
   logic                    w_drop;
   logic [DATA_W-1:0]       w_push_data;
   logic [c_byte_cnt_w-1:0] r_byte_cnt;

   logic [c_pend_w-1:0]     r_pending;
   logic                    w_cmd_full;
   logic                    w_cmd_last;
   logic                    w_cmd;
   logic [5:0]              w_cmd_bl;
   logic [29:0]             r_next_addr;

   logic                    r_wr_en;
   logic [DATA_W-1:0]       r_wr_data;
   logic                    r_cmd_en;
   logic [5:0]              r_cmd_bl;
   logic [29:0]             r_cmd_addr;
   logic                    r_overflow;

   cam_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .cam_pclk  (cam_pclk),
      .cam_href  (cam_href),
      .cam_vsync (cam_vsync),
      .cam_data  (cam_data),
      .pclk_rise (w_pclk_rise),
      .href_s    (w_href_s),
      .vsync_s   (w_vsync_s),
      .data_s    (w_byte)
   );

   assign w_take       = w_pclk_rise & w_href_s;
   assign w_capture    = (r_state == ST_CAPTURE);
   assign w_start      = (r_state == ST_IDLE) && begin_cap;
   assign w_abort      = abort && (r_state != ST_IDLE);
   assign w_vsync_rise = w_vsync_s & ~r_vsync_d;

`ifdef CAM_DECIMATE_EN
   localparam int c_pix_w = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam logic [c_pix_w-1:0] c_pix_last = c_pix_w'(BYTES_PER_PIX - 1);

   logic [c_pix_w-1:0] r_pix_byte;
   logic               r_pix_odd;
   logic               r_line_odd;
   logic               r_href_d;

   // Track pixel and line parity inside the active frame; href falling ends a line
   always_ff @(posedge clk) begin
      if (rst || !w_capture) begin
         r_pix_byte <= '0;
         r_pix_odd  <= 1'b0;
         r_line_odd <= 1'b0;
         r_href_d   <= 1'b0;
      end else begin
         r_href_d <= w_href_s;
         if (r_href_d && !w_href_s) begin
            r_pix_byte <= '0;
            r_pix_odd  <= 1'b0;
            r_line_odd <= ~r_line_odd;
         end else if (w_take) begin
            if (r_pix_byte == c_pix_last) begin
               r_pix_byte <= '0;
               r_pix_odd  <= ~r_pix_odd;
            end else begin
               r_pix_byte <= r_pix_byte + 1'b1;
            end
         end
      end
   end

   assign w_store = w_capture && w_take && !r_pix_odd && !r_line_odd;
`else
   assign w_store = w_capture && w_take;
`endif

   assign w_cnt_hit = w_store && ((r_byte_cnt + 1'b1) == c_total_cnt);

   // Insert the incoming byte into its lane of the word being built
   always_comb begin
      w_word = r_pack_data;
      for (int i = 0; i < c_bpw; i++) begin
         if (c_pack_w'(i) == r_pack_cnt) begin
            w_word[i*8 +: 8] = w_byte;
         end
      end
   end

   assign w_word_done  = w_store && (r_pack_cnt == c_pack_last);
   assign w_flush_push = (r_state == ST_FLUSH) && (r_pack_cnt != '0);
   assign w_push_req   = w_word_done || w_flush_push;
   assign w_push_data  = w_word_done ? w_word : r_pack_data;
   assign w_push       = w_push_req && !wr_full && !w_abort;
   assign w_drop       = w_push_req && wr_full && !w_abort;

   // Full bursts any time enough words are pending; short burst only once the
   // last partial word has been pushed in FLUSH
   assign w_cmd_full = (r_pending >= c_burst) && !cmd_full && !w_abort;
   assign w_cmd_last = (r_state == ST_FLUSH) && (r_pack_cnt == '0) &&
                       (r_pending != '0) && (r_pending < c_burst) &&
                       !cmd_full && !w_abort;
   assign w_cmd      = w_cmd_full || w_cmd_last;
   assign w_cmd_bl   = w_cmd_full ? c_bl_full : (r_pending[5:0] - 6'd1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort overrides every active state
   always_comb begin
      w_state_nxt = r_state;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (begin_cap)                 w_state_nxt = ST_ARM;
            ST_ARM:     if (w_vsync_s)                 w_state_nxt = ST_SYNC;
            ST_SYNC:    if (!w_vsync_s)                w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (w_vsync_rise || w_cnt_hit) w_state_nxt = ST_FLUSH;
            ST_FLUSH:   if ((r_pack_cnt == '0) && (r_pending == '0))
                                                       w_state_nxt = ST_DONE;
            ST_DONE:                                   w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      busy       = (r_state != ST_IDLE);
      frame_done = (r_state == ST_DONE);
   end

   // Previous synchronised vsync for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vsync_d <= 1'b0;
      end else begin
         r_vsync_d <= w_vsync_s;
      end
   end

   // Byte packing and per-frame byte count
   always_ff @(posedge clk) begin
      if (rst || w_start || w_abort) begin
         r_pack_cnt  <= '0;
         r_pack_data <= '0;
         r_byte_cnt  <= '0;
      end else if (w_store) begin
         r_byte_cnt <= r_byte_cnt + 1'b1;
         if (w_word_done) begin
            r_pack_cnt  <= '0;
            r_pack_data <= '0;
         end else begin
            r_pack_data <= w_word;
            r_pack_cnt  <= r_pack_cnt + 1'b1;
         end
      end else if (w_flush_push) begin
         r_pack_cnt  <= '0;
         r_pack_data <= '0;
      end
   end

   // FIFO push, burst commands, address and pending-word bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_en     <= 1'b0;
         r_wr_data   <= '0;
         r_cmd_en    <= 1'b0;
         r_cmd_bl    <= '0;
         r_cmd_addr  <= BASE_ADDR;
         r_next_addr <= BASE_ADDR;
         r_pending   <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_wr_en  <= w_push;
         r_cmd_en <= w_cmd;
         if (w_push) begin
            r_wr_data <= w_push_data;
         end
         if (w_start) begin
            r_cmd_addr  <= BASE_ADDR;
            r_next_addr <= BASE_ADDR;
            r_pending   <= '0;
            r_overflow  <= 1'b0;
         end else if (w_abort) begin
            r_pending <= '0;
         end else begin
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
            if (w_cmd) begin
               r_cmd_bl    <= w_cmd_bl;
               r_cmd_addr  <= r_next_addr;
               r_next_addr <= r_next_addr + c_addr_step;
            end
            if (w_cmd_last) begin
               r_pending <= '0;
            end else begin
               r_pending <= r_pending + {{(c_pend_w-1){1'b0}}, w_push}
                                      - (w_cmd_full ? c_burst : '0);
            end
         end
      end
   end

   assign wr_en    = r_wr_en;
   assign wr_data  = r_wr_data;
   assign cmd_en   = r_cmd_en;
   assign cmd_bl   = r_cmd_bl;
   assign cmd_addr = r_cmd_addr;
   assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cam_frame_writer.sv
//------------------------------------------------------------------------------
// Module      : tb_cam_frame_writer
// Description : Self-checking bench for cam_frame_writer with a small frame
//               (4x2 pixels, 2 bytes/pixel, 32-bit words, 2-word bursts).
//               Expected words/commands are queued as frames are driven and
//               compared as the DUT emits them.
//               With CAM_DECIMATE_EN defined a 4x4 decimated frame is used.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cam_frame_writer;

   localparam int H_RES = 4;
`ifdef CAM_DECIMATE_EN
   localparam int V_RES = 4;
`else
   localparam int V_RES = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        begin_cap;
   logic        abort;
   logic        busy;
   logic        frame_done;
   logic        overflow;
   logic        cam_pclk;
   logic        cam_href;
   logic        cam_vsync;
   logic [7:0]  cam_data;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        wr_full;
   logic        cmd_en;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_addr;
   logic        cmd_full;

   always #5 clk = ~clk;

   cam_frame_writer #(
      .H_RES         (H_RES),
      .V_RES         (V_RES),
      .BYTES_PER_PIX (2),
      .DATA_W        (32),
      .BURST_LEN     (2),
      .BASE_ADDR     (30'h0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .begin_cap  (begin_cap),
      .abort      (abort),
      .busy       (busy),
      .frame_done (frame_done),
      .overflow   (overflow),
      .cam_pclk   (cam_pclk),
      .cam_href   (cam_href),
      .cam_vsync  (cam_vsync),
      .cam_data   (cam_data),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_full    (wr_full),
      .cmd_en     (cmd_en),
      .cmd_bl     (cmd_bl),
      .cmd_addr   (cmd_addr),
      .cmd_full   (cmd_full)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_done   = 0;
   int          n_wr     = 0;
   int          n_cmd    = 0;
   logic [31:0] exp_words[$];
   logic [35:0] exp_cmds[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Scoreboard side: compare every push/command against the queued expectation
   always @(negedge clk) begin
      if (wr_en) begin
         n_wr++;
         check("wr_expected", 64'(exp_words.size() != 0), 64'd1);
         if (exp_words.size() != 0) check("wr_data", 64'(wr_data), 64'(exp_words.pop_front()));
      end
      if (cmd_en) begin
         n_cmd++;
         check("cmd_expected", 64'(exp_cmds.size() != 0), 64'd1);
         if (exp_cmds.size() != 0) check("cmd_bl_addr", 64'({cmd_bl, cmd_addr}), 64'(exp_cmds.pop_front()));
      end
      if (frame_done) n_done++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cam_byte(input int b);
      cam_data = 8'(b);
      cam_href = 1'b1;
      tick(3);
      cam_pclk = 1'b1;
      tick(3);
      cam_pclk = 1'b0;
   endtask

   task automatic send_line(input int first, input int n);
      for (int i = 0; i < n; i++) cam_byte(first + i);
      cam_href = 1'b0;
      tick(4);
   endtask

   task automatic start_frame();
      cam_vsync = 1'b1;
      begin_cap = 1'b1;
      tick(1);
      begin_cap = 1'b0;
      tick(6);
      cam_vsync = 1'b0;
      tick(6);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 2000) begin
         tick(1);
         k++;
      end
      check(tag, 64'(busy), 64'd0);
   endtask

   // Model: bytes 0..nbytes-1 packed little-endian, zero-padded, word
   // drop_idx dropped; remaining words split into 2-word bursts from address 0
   task automatic expect_frame(input int nbytes, input int drop_idx);
      int          nw;
      int          kept;
      int          n;
      logic [31:0] word;
      nw   = (nbytes + 3) / 4;
      kept = 0;
      for (int w = 0; w < nw; w++) begin
         word = '0;
         for (int b = 0; b < 4; b++)
            if (w*4 + b < nbytes) word[b*8 +: 8] = 8'(w*4 + b);
         if (w != drop_idx) begin
            exp_words.push_back(word);
            kept++;
         end
      end
      for (int c = 0; c*2 < kept; c++) begin
         n = (kept - c*2 >= 2) ? 2 : kept - c*2;
         exp_cmds.push_back({6'(n - 1), 30'(c * 8)});
      end
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_words_left"}, 64'(exp_words.size()), 64'd0);
      check({tag, "_cmds_left"},  64'(exp_cmds.size()),  64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int d0;
      int w0;
      int c0;
      rst = 1'b1; begin_cap = 1'b0; abort = 1'b0;
      cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; cam_data = 8'h00;
      wr_full = 1'b0; cmd_full = 1'b0;
      tick(4);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_wr_en",      64'(wr_en),      64'd0);
      check("rst_cmd_en",     64'(cmd_en),     64'd0);
      check("rst_overflow",   64'(overflow),   64'd0);
      check("rst_wr_data",    64'(wr_data),    64'd0);
      check("rst_cmd_bl",     64'(cmd_bl),     64'd0);
      check("rst_cmd_addr",   64'(cmd_addr),   64'd0);
      rst = 1'b0;
      tick(2);

`ifdef CAM_DECIMATE_EN
      // Decimated 4x4 frame: pixels 0,2 of lines 0,2 survive
      d0 = n_done;
      exp_words.push_back(32'h05040100);
      exp_words.push_back(32'h15141110);
      exp_cmds.push_back({6'd1, 30'd0});
      start_frame();
      check("dec_busy", 64'(busy), 64'd1);
      for (int l = 0; l < 4; l++) send_line(l*8, 8);
      cam_vsync = 1'b1;
      wait_idle("dec_idle");
      check("dec_done", 64'(n_done - d0), 64'd1);
      check_drained("dec");
`else
      // Full frame, count-terminated
      d0 = n_done;
      expect_frame(16, -1);
      start_frame();
      check("full_busy", 64'(busy), 64'd1);
      send_line(0, 8);
      send_line(8, 8);
      wait_idle("full_idle");
      cam_vsync = 1'b1;
      check("full_done", 64'(n_done - d0), 64'd1);
      check_drained("full");

      // Early vsync after 14 bytes: padded last word, short tail
      d0 = n_done;
      expect_frame(14, -1);
      start_frame();
      send_line(0, 8);
      send_line(8, 6);
      cam_vsync = 1'b1;
      wait_idle("early_idle");
      check("early_done", 64'(n_done - d0), 64'd1);
      check_drained("early");

      // wr_full during word 2: dropped word, sticky overflow
      d0 = n_done;
      expect_frame(16, 1);
      start_frame();
      for (int i = 0; i < 4; i++) cam_byte(i);
      wr_full = 1'b1;
      for (int i = 4; i < 8; i++) cam_byte(i);
      tick(3);
      wr_full = 1'b0;
      cam_href = 1'b0;
      tick(4);
      send_line(8, 8);
      wait_idle("ovf_idle");
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_done", 64'(n_done - d0), 64'd1);
      check_drained("ovf");
      begin_cap = 1'b1;
      tick(1);
      begin_cap = 1'b0;
      check("ovf_cleared", 64'(overflow), 64'd0);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("ovf_abort_idle", 64'(busy), 64'd0);

      // cmd_full holds back the first burst
      d0 = n_done;
      cmd_full = 1'b1;
      c0 = n_cmd;
      expect_frame(16, -1);
      start_frame();
      send_line(0, 8);
      tick(4);
      check("cmdfull_held", 64'(n_cmd - c0), 64'd0);
      cmd_full = 1'b0;
      send_line(8, 8);
      wait_idle("cmdfull_idle");
      cam_vsync = 1'b1;
      check("cmdfull_cmds", 64'(n_cmd - c0), 64'd2);
      check("cmdfull_done", 64'(n_done - d0), 64'd1);
      check_drained("cmdfull");

      // abort after 5 bytes
      d0 = n_done; w0 = n_wr; c0 = n_cmd;
      exp_words.push_back(32'h03020100);
      start_frame();
      for (int i = 0; i < 5; i++) cam_byte(i);
      tick(3);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      send_line(5, 11);
      tick(10);
      check("abort_words", 64'(n_wr - w0), 64'd1);
      check("abort_cmds",  64'(n_cmd - c0), 64'd0);
      check("abort_done",  64'(n_done - d0), 64'd0);
      check_drained("abort");

      // rst after 5 bytes
      d0 = n_done; w0 = n_wr; c0 = n_cmd;
      exp_words.push_back(32'h03020100);
      start_frame();
      for (int i = 0; i < 5; i++) cam_byte(i);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rstmid_busy",     64'(busy),     64'd0);
      check("rstmid_wr_en",    64'(wr_en),    64'd0);
      check("rstmid_cmd_addr", 64'(cmd_addr), 64'd0);
      send_line(5, 11);
      tick(10);
      check("rstmid_words", 64'(n_wr - w0), 64'd1);
      check("rstmid_cmds",  64'(n_cmd - c0), 64'd0);
      check("rstmid_done",  64'(n_done - d0), 64'd0);
      check_drained("rstmid");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
